// File: rtl/cim_bsacc_pkg.sv
// Shared types, width helpers and limits for the bit-serial accumulate engine.
package cim_bsacc_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam int MIN_PSUM_LAT = 1;

   function automatic int SEL_W(input int max_in_bits);
      return (max_in_bits > 1) ? $clog2(max_in_bits) : 1;
   endfunction

   function automatic int BITS_W(input int max_in_bits);
      return $clog2(max_in_bits + 1);
   endfunction

endpackage

// File: rtl/cim_bsacc_lane.sv
// One channel's shift-accumulate register: w <= (w<<1) +/- psum with signed overflow flag.
// Updates on the edge closing a tagged cycle; clear wins over update. Requires ACC_W > PSUM_W.
module cim_bsacc_lane #(
   parameter int PSUM_W = 14,
   parameter int ACC_W  = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_clr,
   input  logic              i_vld,
   input  logic              i_neg,
   input  logic [PSUM_W-1:0] i_psum,
   output logic [ACC_W-1:0]  o_w,
   output logic              o_ovf
);

   logic [ACC_W-1:0] r_w;
   logic [ACC_W-1:0] w_ext, w_p, w_shl, w_sum;
   logic             w_shl_ovf, w_add_ovf;

   always_comb begin
      w_ext     = {{(ACC_W-PSUM_W){i_psum[PSUM_W-1]}}, i_psum};
      w_p       = i_neg ? -w_ext : w_ext;
      w_shl     = {r_w[ACC_W-2:0], 1'b0};
      w_sum     = w_shl + w_p;
      // shift overflows when the two top bits differ; add when same-sign operands flip sign
      w_shl_ovf = r_w[ACC_W-1] ^ r_w[ACC_W-2];
      w_add_ovf = (w_shl[ACC_W-1] == w_p[ACC_W-1]) && (w_sum[ACC_W-1] != w_shl[ACC_W-1]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)      r_w <= '0;
      else if (i_clr) r_w <= '0;
      else if (i_vld) r_w <= w_sum;
   end

   assign o_w   = r_w;
   assign o_ovf = i_vld && !i_clr && (w_shl_ovf || w_add_ovf);

endmodule

// File: rtl/cim_bsacc_engine.sv
// Bit-serial plane sequencer (MSB first) with NCH shift-accumulate lanes and held, optionally accumulated results.
// Result valid in_bits+PSUM_LAT+1 cycles after start; held in DONE until out_ready, new starts ignored meanwhile.
module cim_bsacc_engine
   import cim_bsacc_pkg::*;
#(
   parameter int NCH         = 2,
   parameter int PSUM_W      = 14,
   parameter int ACC_W       = 32,
   parameter int MAX_IN_BITS = 16,
   parameter int PSUM_LAT    = 1,
   localparam int SW = SEL_W(MAX_IN_BITS),
   localparam int BW = BITS_W(MAX_IN_BITS)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [BW-1:0]         in_bits,
   input  logic                  in_signed,
   input  logic                  acc_en,
   input  logic                  abort,
   input  logic [NCH*PSUM_W-1:0] psum,
   output logic [SW-1:0]         sel,
   output logic                  sel_valid,
   output logic                  busy,
   output logic [NCH*ACC_W-1:0]  out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  ovf,
   output logic                  cfg_err
);

   localparam int            LAT   = (PSUM_LAT < MIN_PSUM_LAT) ? MIN_PSUM_LAT : PSUM_LAT;
   localparam logic [BW-1:0] MAX_B = BW'(MAX_IN_BITS);

   state_t                    r_state;
   logic [SW-1:0]             r_sel;
   logic                      r_sel_valid, r_msb_pl, r_signed, r_acc_en;
   logic                      r_out_valid, r_ovf, r_cfg_err;
   logic [LAT-1:0]            r_pipe_vld, r_pipe_msb;
   logic [NCH-1:0][ACC_W-1:0] r_out_data, w_w, w_addend, w_fin;
   logic [NCH-1:0]            w_lane_ovf, w_fin_ovf;
   logic                      w_cfg_ok, w_accept, w_abort, w_clr, w_tail_vld, w_tail_msb;

   assign w_cfg_ok   = (in_bits != '0) && (in_bits <= MAX_B);
   assign w_accept   = (r_state == IDLE) && start && w_cfg_ok;
   assign w_abort    = abort && (r_state != IDLE);
   assign w_clr      = w_accept || w_abort;
   assign w_tail_vld = r_pipe_vld[LAT-1];
   assign w_tail_msb = r_pipe_msb[LAT-1];

   for (genvar k = 0; k < NCH; k++) begin : g_lane
      cim_bsacc_lane #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) u_lane (
         .clk    (clk),
         .rstn   (rstn),
         .i_clr  (w_clr),
         .i_vld  (w_tail_vld),
         .i_neg  (r_signed && w_tail_msb),
         .i_psum (psum[k*PSUM_W +: PSUM_W]),
         .o_w    (w_w[k]),
         .o_ovf  (w_lane_ovf[k])
      );
      assign w_addend[k]  = r_acc_en ? r_out_data[k] : '0;
      assign w_fin[k]     = w_w[k] + w_addend[k];
      assign w_fin_ovf[k] = (w_w[k][ACC_W-1] == w_addend[k][ACC_W-1]) &&
                            (w_fin[k][ACC_W-1] != w_w[k][ACC_W-1]);
   end

   // Each issued plane travels LAT stages so it lines up with the psum it produced.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pipe_vld <= '0;
         r_pipe_msb <= '0;
      end else if (w_abort) begin
         r_pipe_vld <= '0;
         r_pipe_msb <= '0;
      end else begin
         r_pipe_vld[0] <= r_sel_valid;
         r_pipe_msb[0] <= r_msb_pl;
         for (int i = 1; i < LAT; i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_pipe_msb[i] <= r_pipe_msb[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= IDLE;
         r_sel       <= '0;
         r_sel_valid <= 1'b0;
         r_msb_pl    <= 1'b0;
         r_signed    <= 1'b0;
         r_acc_en    <= 1'b0;
         r_out_valid <= 1'b0;
         r_ovf       <= 1'b0;
         r_cfg_err   <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_cfg_err <= 1'b0;
         if (|w_lane_ovf) r_ovf <= 1'b1;
         if (w_abort) begin
            r_state     <= IDLE;
            r_sel_valid <= 1'b0;
            r_out_valid <= 1'b0;
         end else begin
            case (r_state)
               IDLE: if (start) begin
                  if (w_cfg_ok) begin
                     r_state     <= RUN;
                     r_sel       <= SW'(in_bits - BW'(1));
                     r_sel_valid <= 1'b1;
                     r_msb_pl    <= 1'b1;
                     r_signed    <= in_signed;
                     r_acc_en    <= acc_en;
                     r_ovf       <= 1'b0;
                  end else begin
                     r_cfg_err <= 1'b1;
                  end
               end
               RUN: begin
                  r_msb_pl <= 1'b0;
                  if (r_sel == '0) begin
                     r_sel_valid <= 1'b0;
                     r_state     <= DRAIN;
                  end else begin
                     r_sel <= r_sel - SW'(1);
                  end
               end
               DRAIN: if (!(|r_pipe_vld)) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_fin;
                  if (|w_fin_ovf) r_ovf <= 1'b1;
               end
               DONE: if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign sel       = r_sel;
   assign sel_valid = r_sel_valid;
   assign busy      = (r_state != IDLE);
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign ovf       = r_ovf;
   assign cfg_err   = r_cfg_err;

endmodule
